// File: rtl/ipih_pkg.sv
// Shared defaults, sweep state encoding and helpers for the IPI histogrammer.
// Optional overflow counter in the top is enabled by IPIH_OVERFLOW_BIN_EN.
package ipih_pkg;

  localparam int NCH_DEF   = 4;
  localparam int NBINS_DEF = 64;
  localparam int CW_DEF    = 32;
  localparam int IW_DEF    = 8;

  typedef enum logic {
    ST_SWEEP = 1'b0,
    ST_RUN   = 1'b1
  } sweep_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Saturation ceiling for a counter of width w (w <= 64).
  function automatic logic [63:0] all_ones(input int w);
    return (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
  endfunction

endpackage

// File: rtl/ipih_bin_ram.sv
// Histogram bin storage: sweep-clear write, pipelined saturating read-modify-write
// with one-deep forwarding, and an independent registered read port.
module ipih_bin_ram
  import ipih_pkg::*;
#(
  parameter int NBINS = NBINS_DEF,
  parameter int CW    = CW_DEF,
  parameter int AW    = clog2(NBINS)
) (
  input  logic          clkin,
  input  logic          reset,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic          inc_en,
  input  logic [AW-1:0] inc_addr,
  input  logic [AW-1:0] rd_addr,
  output logic [CW-1:0] rd_data
);

  localparam logic [CW-1:0] CMAX = CW'(all_ones(CW));

  logic [CW-1:0] mem [NBINS];
  logic          inc_v_reg;
  logic [AW-1:0] inc_addr_reg;
  logic [CW-1:0] rmw_q_reg;
  logic          fwd_v_reg;
  logic [CW-1:0] fwd_d_reg;
  logic [CW-1:0] cur_val;
  logic [CW-1:0] new_val;

  // A request one cycle behind a write to the same bin read stale RAM data.
  assign cur_val = fwd_v_reg ? fwd_d_reg : rmw_q_reg;
  assign new_val = (cur_val == CMAX) ? cur_val : cur_val + CW'(1);

  always_ff @(posedge clkin) begin
    rmw_q_reg <= mem[inc_addr];
    if (clr_en)
      mem[clr_addr] <= '0;
    else if (inc_v_reg)
      mem[inc_addr_reg] <= new_val;
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      inc_v_reg    <= 1'b0;
      inc_addr_reg <= '0;
      fwd_v_reg    <= 1'b0;
      fwd_d_reg    <= '0;
      rd_data      <= '0;
    end else begin
      inc_v_reg    <= inc_en;
      inc_addr_reg <= inc_addr;
      fwd_v_reg    <= inc_v_reg && inc_en && (inc_addr_reg == inc_addr);
      fwd_d_reg    <= new_val;
      rd_data      <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/ipi_histogrammer.sv
// Per-channel hit counter and inter-photon-interval histogrammer.
// Define IPIH_OVERFLOW_BIN_EN to add ovf_count for intervals beyond the last bin.
module ipi_histogrammer
  import ipih_pkg::*;
#(
  parameter int NCH   = NCH_DEF,
  parameter int NBINS = NBINS_DEF,
  parameter int CW    = CW_DEF,
  parameter int IW    = IW_DEF
) (
  input  logic                    clkin,
  input  logic                    reset,
  input  logic [NCH-1:0]          hits,
  input  logic [NCH-1:0]          chan_mask,
  input  logic                    coinc_mode,
  input  logic                    veto,
  output logic [NCH-1:0]          out,
  output logic [NCH*CW-1:0]       hit_count,
  input  logic [clog2(NBINS)-1:0] rd_addr,
  output logic [CW-1:0]           rd_data,
`ifdef IPIH_OVERFLOW_BIN_EN
  output logic [CW-1:0]           ovf_count,
`endif
  output logic                    busy
);

  localparam int              AW      = clog2(NBINS);
  localparam logic [CW-1:0]   CMAX    = CW'(all_ones(CW));
  localparam logic [IW-1:0]   IMAX    = IW'(all_ones(IW));
  localparam logic [IW:0]     NBINS_W = (IW+1)'(NBINS);

  logic [NCH-1:0] hits_reg, mask_reg, masked;
  logic           mode_reg, veto_reg;
  logic           evt, hist_evt, in_range, inc_en;
  logic [IW-1:0]  ic_reg;
  logic           prev_valid_reg;
  sweep_state_t   state_reg, state_next;
  logic [AW-1:0]  ptr_reg, ptr_next;

  always_ff @(posedge clkin) begin
    if (reset) begin
      hits_reg <= '0;
      mask_reg <= '0;
      mode_reg <= 1'b0;
      veto_reg <= 1'b0;
    end else begin
      hits_reg <= hits;
      mask_reg <= chan_mask;
      mode_reg <= coinc_mode;
      veto_reg <= veto;
    end
  end

  assign out      = hits_reg;
  assign masked   = hits_reg & mask_reg;
  assign evt      = !veto_reg && (mask_reg != '0) &&
                    (mode_reg ? (masked == mask_reg) : (masked != '0));
  assign busy     = (state_reg == ST_SWEEP);
  assign hist_evt = evt && prev_valid_reg && !busy;
  assign in_range = {1'b0, ic_reg} < NBINS_W;
  assign inc_en   = hist_evt && in_range;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_cnt
      logic [CW-1:0] cnt_reg;
      always_ff @(posedge clkin) begin
        if (reset)
          cnt_reg <= '0;
        else if (hits[gi] && cnt_reg != CMAX)
          cnt_reg <= cnt_reg + CW'(1);
      end
      assign hit_count[gi*CW +: CW] = cnt_reg;
    end
  endgenerate

  always_ff @(posedge clkin) begin
    if (reset) begin
      state_reg <= ST_SWEEP;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      ST_SWEEP: begin
        ptr_next = ptr_reg + AW'(1);
        if (ptr_reg == AW'(NBINS - 1))
          state_next = ST_RUN;
      end
      default: ptr_next = '0;
    endcase
  end

  // ic counts non-event cycles since the last qualifying event.
  always_ff @(posedge clkin) begin
    if (reset) begin
      ic_reg         <= '0;
      prev_valid_reg <= 1'b0;
    end else begin
      if (evt)
        ic_reg <= '0;
      else if (ic_reg != IMAX)
        ic_reg <= ic_reg + IW'(1);
      if (busy)
        prev_valid_reg <= 1'b0;
      else if (evt)
        prev_valid_reg <= 1'b1;
    end
  end

  ipih_bin_ram #(
    .NBINS (NBINS),
    .CW    (CW),
    .AW    (AW)
  ) u_bins (
    .clkin    (clkin),
    .reset    (reset),
    .clr_en   (busy && !reset),
    .clr_addr (ptr_reg),
    .inc_en   (inc_en),
    .inc_addr (ic_reg[AW-1:0]),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
  );

`ifdef IPIH_OVERFLOW_BIN_EN
  logic [CW-1:0] ovf_reg;
  always_ff @(posedge clkin) begin
    if (reset)
      ovf_reg <= '0;
    else if (hist_evt && !in_range && ovf_reg != CMAX)
      ovf_reg <= ovf_reg + CW'(1);
  end
  assign ovf_count = ovf_reg;
`endif

endmodule

// File: tb/tb_ipi_histogrammer.sv
// Randomised and directed bench for ipi_histogrammer: a 32-bit and a 4-bit build
// share one stimulus stream and are checked against an event-time reference model.
module tb_ipi_histogrammer;

  logic        clkin = 1'b0;
  logic        reset;
  logic [3:0]  hits, chan_mask;
  logic        coinc_mode, veto;
  logic [5:0]  rd_addr;
  logic [3:0]  out_a, out_b;
  logic [127:0] hc_a;
  logic [15:0] hc_b;
  logic [31:0] rd_a;
  logic [3:0]  rd_b;
  logic        busy_a, busy_b;
`ifdef IPIH_OVERFLOW_BIN_EN
  logic [31:0] ovf_a;
  logic [3:0]  ovf_b;
`endif

  int n_chk = 0;
  int n_fail = 0;

  longint m_bin [64];
  longint m_cnt [4];
  longint m_ovf;
  bit     m_pv;
  int     m_t, m_tprev;

  always #5 clkin = ~clkin;

  ipi_histogrammer #(.NCH(4), .NBINS(64), .CW(32), .IW(8)) dut (
    .clkin(clkin), .reset(reset), .hits(hits), .chan_mask(chan_mask),
    .coinc_mode(coinc_mode), .veto(veto), .out(out_a), .hit_count(hc_a),
    .rd_addr(rd_addr), .rd_data(rd_a),
`ifdef IPIH_OVERFLOW_BIN_EN
    .ovf_count(ovf_a),
`endif
    .busy(busy_a)
  );

  ipi_histogrammer #(.NCH(4), .NBINS(64), .CW(4), .IW(8)) dut_s (
    .clkin(clkin), .reset(reset), .hits(hits), .chan_mask(chan_mask),
    .coinc_mode(coinc_mode), .veto(veto), .out(out_b), .hit_count(hc_b),
    .rd_addr(rd_addr), .rd_data(rd_b),
`ifdef IPIH_OVERFLOW_BIN_EN
    .ovf_count(ovf_b),
`endif
    .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint sat(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  task automatic model_clear();
    foreach (m_bin[i]) m_bin[i] = 0;
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_ovf = 0;
    m_pv = 1'b0;
    m_t = 0;
    m_tprev = 0;
  endtask

  // One input cycle; the model works on event times, not on DUT pipeline state.
  task automatic cyc(input logic [3:0] h, input logic [3:0] m, input logic md, input logic v);
    logic [3:0] hm;
    int iv;
    hits = h; chan_mask = m; coinc_mode = md; veto = v;
    hm = h & m;
    if (!v && m != 4'd0 && (md ? (hm == m) : (hm != 4'd0))) begin
      if (m_pv) begin
        iv = m_t - m_tprev - 1;
        if (iv > 255) iv = 255;
        if (iv < 64) m_bin[iv]++;
        else m_ovf++;
      end
      m_pv = 1'b1;
      m_tprev = m_t;
    end
    for (int i = 0; i < 4; i++) m_cnt[i] += longint'(h[i]);
    m_t++;
    tick();
    chk("out_a", 64'(out_a), 64'(h));
    chk("out_b", 64'(out_b), 64'(h));
  endtask

  task automatic do_reset(input int abort_at);
    int n_a, n_b;
    hits = 4'd0; chan_mask = 4'd0; coinc_mode = 1'b0; veto = 1'b0;
    reset = 1'b1;
    tick();
    chk("rst_out", 64'({out_a, out_b}), 64'd0);
    chk("rst_hc_a", 64'(hc_a[63:0] | hc_a[127:64]), 64'd0);
    chk("rst_hc_b", 64'(hc_b), 64'd0);
    chk("rst_rd", 64'({rd_a, rd_b}), 64'd0);
    chk("rst_busy", 64'({busy_a, busy_b}), 64'd3);
    reset = 1'b0;
    model_clear();
    n_a = 0; n_b = 0;
    for (int n = 0; n < 200; n++) begin
      if (!busy_a && !busy_b) break;
      if (abort_at != 0 && n == abort_at) break;
      tick();
      if (busy_a || n_a != n) n_a += 0;
      n_a = busy_a ? n_a : n_a;
      if (n_a == n) n_a = n + 1;
      if (n_b == n) n_b = n + 1;
      if (!busy_a && n_a == n + 1) n_a = n + 1;
    end
    if (abort_at == 0) begin
      chk("busy_len_a", 64'(n_a), 64'd64);
      chk("busy_len_b", 64'(n_b), 64'd64);
      chk("busy_end", 64'({busy_a, busy_b}), 64'd0);
    end else begin
      chk("busy_mid", 64'({busy_a, busy_b}), 64'd3);
    end
  endtask

  task automatic dump(input string tag);
    repeat (4) cyc(4'd0, 4'd0, 1'b0, 1'b0);
    for (int a = 0; a < 64; a++) begin
      rd_addr = 6'(a);
      cyc(4'd0, 4'd0, 1'b0, 1'b0);
      chk($sformatf("%s_bin%0d_a", tag, a), 64'(rd_a), 64'(sat(m_bin[a], 32)));
      chk($sformatf("%s_bin%0d_b", tag, a), 64'(rd_b), 64'(sat(m_bin[a], 4)));
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_hc%0d_a", tag, i), 64'(hc_a[i*32 +: 32]), 64'(sat(m_cnt[i], 32)));
      chk($sformatf("%s_hc%0d_b", tag, i), 64'(hc_b[i*4 +: 4]), 64'(sat(m_cnt[i], 4)));
    end
`ifdef IPIH_OVERFLOW_BIN_EN
    chk({tag, "_ovf_a"}, 64'(ovf_a), 64'(sat(m_ovf, 32)));
    chk({tag, "_ovf_b"}, 64'(ovf_b), 64'(sat(m_ovf, 4)));
`endif
    $display("dump %s done at model cycle %0d", tag, m_t);
  endtask

  initial begin
    logic [3:0] rm, rh;
    logic       rmd;
    bit         sparse;
    reset = 1'b1; hits = 4'd0; chan_mask = 4'd0; coinc_mode = 1'b0; veto = 1'b0;
    rd_addr = 6'd0;

    do_reset(0);
    dump("init");

    // Single-channel events every 5 cycles land in bin 4.
    do_reset(0);
    for (int k = 0; k < 4; k++) begin
      cyc(4'b0001, 4'b0001, 1'b0, 1'b0);
      if (k < 3) repeat (4) cyc(4'd0, 4'b0001, 1'b0, 1'b0);
    end
    dump("ipi");
    rd_addr = 6'd4;
    cyc(4'd0, 4'd0, 1'b0, 1'b0);
    chk("ipi_bin4_const", 64'(rd_a), 64'd3);

    // Coincidence: partial hit ignored, gap 3 lands in bin 2, vetoed event ignored.
    do_reset(0);
    cyc(4'b0001, 4'b0011, 1'b1, 1'b0);
    repeat (2) cyc(4'd0, 4'b0011, 1'b1, 1'b0);
    cyc(4'b0011, 4'b0011, 1'b1, 1'b0);
    repeat (2) cyc(4'd0, 4'b0011, 1'b1, 1'b0);
    cyc(4'b0011, 4'b0011, 1'b1, 1'b0);
    repeat (2) cyc(4'd0, 4'b0011, 1'b1, 1'b0);
    cyc(4'b0011, 4'b0011, 1'b1, 1'b1);
    dump("coinc");

    // Back-to-back events on bin 0 exercise the forwarding path.
    do_reset(0);
    repeat (10) cyc(4'b0001, 4'b0001, 1'b0, 1'b0);
    dump("b2b");

    // Long gap overflows the histogram range.
    do_reset(0);
    cyc(4'b0001, 4'b0001, 1'b0, 1'b0);
    repeat (200) cyc(4'd0, 4'b0001, 1'b0, 1'b0);
    cyc(4'b0001, 4'b0001, 1'b0, 1'b0);
    dump("gap");

    // Saturation of the narrow build.
    do_reset(0);
    repeat (20) cyc(4'b0001, 4'b0001, 1'b0, 1'b0);
    dump("sat");

    // Randomised traffic with alternating dense and sparse phases.
    do_reset(0);
    rm = 4'b0001; rmd = 1'b0; sparse = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (k % 64 == 0) begin
        rm = 4'($urandom);
        rmd = 1'($urandom);
      end
      if (k % 500 == 0) sparse = ~sparse;
      if (sparse) rh = ($urandom_range(0, 79) == 0) ? 4'($urandom) : 4'd0;
      else        rh = 4'($urandom) & 4'($urandom);
      if ($urandom_range(0, 3) == 0) rh = rm;
      cyc(rh, rm, rmd, ($urandom_range(0, 7) == 0));
      if (k % 1000 == 999) dump($sformatf("rand%0d", k / 1000));
    end

    // Reset part-way through the sweep restarts it from bin 0.
    do_reset(30);
    do_reset(0);
    dump("midsweep");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
